// File: rtl/key_debounce_pulse_pkg.sv
// Shared types and constants for the pushbutton debounce / pulse block.
package key_debounce_pkg;

   typedef enum logic [2:0] {IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT} kd_state_t;

   localparam int SYNC_STAGES = 2;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce_pulse_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to 1 (key released).
module sync2
   import key_debounce_pkg::*;
(
   input  logic Clock,
   input  logic Reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sr;

   always_ff @(posedge Clock) begin
      if (Reset) sr <= '1;
      else       sr <= {sr[SYNC_STAGES-2:0], d};
   end

   assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces an active-low pushbutton into a clean level plus 1-cycle press/auto-repeat strobes.
//
// state        | meaning
// IDLE         | key released, waiting for first pressed sample
// PRESS_WAIT   | key seen pressed, timing the debounce window
// HELD         | press accepted, timing the delay to the first repeat
// REPEAT       | auto-repeating, one strobe every REPEAT_PERIOD cycles
// RELEASE_WAIT | key seen released, timing the release debounce window
module key_debounce_pulse
   import key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic KEY_n,
   output logic Pressed,
   output logic Pulse,
   output logic RepeatActive
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));

   localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

   logic      key_sync;
   logic      ks;
   kd_state_t state, state_n;
   logic [DW-1:0] dcnt, dcnt_n;
   logic [RW-1:0] rcnt, rcnt_n;
   logic      pulse_n;

   sync2 u_sync (
      .Clock (Clock),
      .Reset (Reset),
      .d     (KEY_n),
      .q     (key_sync)
   );

   assign ks = ~key_sync;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= IDLE;
         dcnt         <= '0;
         rcnt         <= '0;
         Pulse        <= 1'b0;
         Pressed      <= 1'b0;
         RepeatActive <= 1'b0;
      end else begin
         state        <= state_n;
         dcnt         <= dcnt_n;
         rcnt         <= rcnt_n;
         Pulse        <= pulse_n;
         Pressed      <= (state_n == HELD) || (state_n == REPEAT) || (state_n == RELEASE_WAIT);
         RepeatActive <= (state_n == REPEAT);
      end
   end

   always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      rcnt_n  = rcnt;
      pulse_n = 1'b0;
      case (state)
         IDLE: begin
            if (ks) begin
               state_n = PRESS_WAIT;
               dcnt_n  = '0;
            end
         end
         PRESS_WAIT: begin
            if (!ks) begin
               state_n = IDLE;
               dcnt_n  = '0;
            end else if (dcnt == D_LAST) begin
               state_n = HELD;
               rcnt_n  = '0;
               pulse_n = 1'b1;
            end else begin
               dcnt_n = dcnt + 1'b1;
            end
         end
         HELD: begin
            if (!ks) begin
               state_n = RELEASE_WAIT;
               dcnt_n  = '0;
            end else if ((REPEAT_EN != 0) && (rcnt == RD_LAST)) begin
               state_n = REPEAT;
               rcnt_n  = '0;
               pulse_n = 1'b1;
            end else if (rcnt != RD_LAST) begin
               // saturate so a long hold with repeat disabled never wraps
               rcnt_n = rcnt + 1'b1;
            end
         end
         REPEAT: begin
            if (!ks) begin
               state_n = RELEASE_WAIT;
               dcnt_n  = '0;
            end else if (rcnt == RP_LAST) begin
               rcnt_n  = '0;
               pulse_n = 1'b1;
            end else begin
               rcnt_n = rcnt + 1'b1;
            end
         end
         RELEASE_WAIT: begin
            if (ks) begin
               state_n = HELD;
               rcnt_n  = '0;
            end else if (dcnt == D_LAST) begin
               state_n = IDLE;
               dcnt_n  = '0;
            end else begin
               dcnt_n = dcnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            dcnt_n  = '0;
            rcnt_n  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench: directed scenarios plus random key traffic against a run-length reference model.
module tb_key_debounce_pulse;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   logic KEY_n = 1'b1;
   logic Pressed, Pulse, RepeatActive;
   logic Pressed2, Pulse2, RepeatActive2;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int   edge_n = 0;
   logic h1 = 1'b1, h2 = 1'b1;
   bit   m_pressed, m_pp, m_rp, m_rep, m_rel;
   int   run, anchor;

   always #5 Clock = ~Clock;

   key_debounce_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
      .Clock(Clock), .Reset(Reset), .KEY_n(KEY_n),
      .Pressed(Pressed), .Pulse(Pulse), .RepeatActive(RepeatActive));

   key_debounce_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_norep (
      .Clock(Clock), .Reset(Reset), .KEY_n(KEY_n),
      .Pressed(Pressed2), .Pulse(Pulse2), .RepeatActive(RepeatActive2));

   // Level flips after D+1 consecutive contrary samples of the delayed key;
   // repeats fall at RD, RD+RP, RD+2RP... cycles after the held phase began.
   task automatic model_step(input logic key, input logic rst);
      bit ks;
      int k;
      if (rst) begin
         h1 = 1'b1; h2 = 1'b1;
         m_pressed = 0; m_pp = 0; m_rp = 0; m_rep = 0; m_rel = 0;
         run = 0; anchor = 0;
         return;
      end
      ks = ~h2;
      h2 = h1;
      h1 = key;
      m_pp = 0;
      m_rp = 0;
      if (!m_pressed) begin
         run = ks ? run + 1 : 0;
         if (run == D + 1) begin
            m_pressed = 1; m_pp = 1; anchor = edge_n; run = 0; m_rel = 0; m_rep = 0;
         end
      end else if (!ks) begin
         m_rel = 1; m_rep = 0; run++;
         if (run == D + 1) begin
            m_pressed = 0; run = 0; m_rel = 0;
         end
      end else if (m_rel) begin
         m_rel = 0; anchor = edge_n; run = 0;
      end else begin
         k = edge_n - anchor;
         if (k >= RD) begin
            m_rep = 1;
            if ((k - RD) % RP == 0) m_rp = 1;
         end
      end
   endtask

   task automatic cyc(input logic key, input logic rst);
      KEY_n = key;
      Reset = rst;
      @(posedge Clock);
      #1;
      edge_n++;
      model_step(key, rst);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         cyc(logic'($urandom_range(0, 1)), 1'b1);
         n_checks++;
         if ({Pressed, Pulse, RepeatActive, Pressed2, Pulse2, RepeatActive2} !== 6'b0)
            $display("FAIL reset_outputs cycle=%0d got=%b exp=000000", i,
                     {Pressed, Pulse, RepeatActive, Pressed2, Pulse2, RepeatActive2});
         else n_pass++;
      end
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
      n_checks++;
      if ({Pressed, Pulse, RepeatActive} !== 3'b000)
         $display("FAIL reset_idle got=%b exp=000", {Pressed, Pulse, RepeatActive});
      else n_pass++;
   endtask

   task automatic test_clean_press();
      for (int i = 1; i <= 12; i++) begin
         cyc(1'b0, 1'b0);
         if (i == 6) begin
            n_checks++;
            if ({Pressed, Pulse} !== 2'b00) $display("FAIL press_early edge=%0d got=%b exp=00", i, {Pressed, Pulse});
            else n_pass++;
         end
         if (i == 7) begin
            n_checks++;
            if ({Pressed, Pulse} !== 2'b11) $display("FAIL press_pulse edge=%0d got=%b exp=11", i, {Pressed, Pulse});
            else n_pass++;
         end
         if (i == 8) begin
            n_checks++;
            if ({Pressed, Pulse} !== 2'b10) $display("FAIL press_pulse_end edge=%0d got=%b exp=10", i, {Pressed, Pulse});
            else n_pass++;
         end
      end
      for (int i = 1; i <= 12; i++) begin
         cyc(1'b1, 1'b0);
         if (i == 6 || i == 7) begin
            n_checks++;
            if (Pressed !== (i == 6)) $display("FAIL release_timing edge=%0d got=%b exp=%b", i, Pressed, (i == 6));
            else n_pass++;
         end
      end
   endtask

   task automatic test_press_bounce();
      logic pat [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      int npulse = 0;
      int pedge  = -1;
      for (int i = 1; i <= 14; i++) begin
         cyc((i <= 4) ? pat[i-1] : 1'b0, 1'b0);
         if (Pulse === 1'b1) begin npulse++; pedge = i; end
      end
      n_checks++;
      if (npulse != 1 || pedge != 4 + 6)
         $display("FAIL press_bounce pulses=%0d at_edge=%0d exp_pulses=1 exp_edge=%0d", npulse, pedge, 10);
      else n_pass++;
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);
   endtask

   task automatic test_auto_repeat();
      int exp_e [9] = '{7, 17, 20, 23, 26, 29, 32, 35, 38};
      int got_e [$];
      int first_rep = -1;
      int np2 = 0;
      bit rep2 = 0;
      for (int i = 1; i <= 40; i++) begin
         cyc(1'b0, 1'b0);
         if (Pulse === 1'b1) got_e.push_back(i);
         if (RepeatActive === 1'b1 && first_rep < 0) first_rep = i;
         if (Pulse2 === 1'b1) np2++;
         if (RepeatActive2 !== 1'b0) rep2 = 1;
      end
      n_checks++;
      if (got_e.size() != 9) $display("FAIL repeat_count got=%0d exp=9", got_e.size());
      else n_pass++;
      for (int j = 0; j < 9 && j < got_e.size(); j++) begin
         n_checks++;
         if (got_e[j] != exp_e[j]) $display("FAIL repeat_edge idx=%0d got=%0d exp=%0d", j, got_e[j], exp_e[j]);
         else n_pass++;
      end
      n_checks++;
      if (first_rep != 17) $display("FAIL repeat_active_start got=%0d exp=17", first_rep);
      else n_pass++;
      n_checks++;
      if (np2 != 1 || rep2) $display("FAIL norepeat pulses=%0d rep_seen=%0d exp_pulses=1 exp_rep_seen=0", np2, rep2);
      else n_pass++;
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);
   endtask

   task automatic test_release_bounce();
      int np = 0;
      bit dropped = 0;
      for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         cyc((i <= 2) ? 1'b1 : 1'b0, 1'b0);
         if (Pulse === 1'b1) np++;
         if (Pressed !== 1'b1) dropped = 1;
      end
      n_checks++;
      if (np != 0 || dropped) $display("FAIL release_bounce pulses=%0d dropped=%0d exp=0/0", np, dropped);
      else n_pass++;
      for (int j = 1; j <= 12; j++) begin
         cyc(1'b1, 1'b0);
         if (j == 6 || j == 7) begin
            n_checks++;
            if (Pressed !== (j == 6)) $display("FAIL release_final edge=%0d got=%b exp=%b", j, Pressed, (j == 6));
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      int np = 0;
      int pedge = -1;
      for (int i = 1; i <= 20; i++) cyc(1'b0, 1'b0);
      n_checks++;
      if (RepeatActive !== 1'b1) $display("FAIL mid_hold_in_repeat got=%b exp=1", RepeatActive);
      else n_pass++;
      cyc(1'b0, 1'b1);
      n_checks++;
      if ({Pressed, Pulse, RepeatActive} !== 3'b000)
         $display("FAIL mid_hold_reset got=%b exp=000", {Pressed, Pulse, RepeatActive});
      else n_pass++;
      for (int i = 1; i <= 10; i++) begin
         cyc(1'b0, 1'b0);
         if (Pulse === 1'b1) begin np++; pedge = i; end
      end
      n_checks++;
      if (np != 1 || pedge != 7) $display("FAIL mid_hold_repress pulses=%0d at_edge=%0d exp=1 at 7", np, pedge);
      else n_pass++;
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic lvl;
      int   len;
      logic prev_pulse = 1'b0;
      int   cycles = 0;
      while (cycles < 3000) begin
         lvl = logic'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            cyc(lvl, ($urandom_range(0, 299) == 0));
            cycles++;
            n_checks++;
            if ({Pressed, Pulse, RepeatActive, Pressed2, Pulse2, RepeatActive2} !==
                {m_pressed, m_pp | m_rp, m_rep, m_pressed, m_pp, 1'b0})
               $display("FAIL random_model edge=%0d got=%b exp=%b", edge_n,
                        {Pressed, Pulse, RepeatActive, Pressed2, Pulse2, RepeatActive2},
                        {m_pressed, m_pp | m_rp, m_rep, m_pressed, m_pp, 1'b0});
            else n_pass++;
            if (prev_pulse === 1'b1) begin
               n_checks++;
               if (Pulse !== 1'b0) $display("FAIL pulse_back_to_back edge=%0d got=%b exp=0", edge_n, Pulse);
               else n_pass++;
            end
            prev_pulse = Pulse;
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_press_bounce();
      test_auto_repeat();
      test_release_bounce();
      test_reset_mid_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
